// File: rtl/regfile_2w2r_sb.sv
// Two-write / two-read register file with fixed write priority, optional
// write-to-read bypass, optional hardwired-zero register and a busy scoreboard.
module regfile_2w2r_sb #(
    parameter int WIDTH    = 64,
    parameter int ADDR_W   = 5,
    parameter int HAS_ZERO = 1,
    parameter int ZERO_REG = 31,
    parameter int BYPASS   = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] RA,
    input  logic [ADDR_W-1:0] RB,
    output logic [WIDTH-1:0]  BusA,
    output logic [WIDTH-1:0]  BusB,
    input  logic [ADDR_W-1:0] RW0,
    input  logic [WIDTH-1:0]  BusW0,
    input  logic              RegWr0,
    input  logic [ADDR_W-1:0] RW1,
    input  logic [WIDTH-1:0]  BusW1,
    input  logic              RegWr1,
    input  logic              SetBusy,
    input  logic [ADDR_W-1:0] BusyRW,
    output logic              BusyA,
    output logic              BusyB,
    output logic              WrConflict
);

    localparam int                DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);
    localparam bit                ZERO_ON  = (HAS_ZERO != 0);
    localparam bit                BYP_ON   = (BYPASS != 0);

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;
    logic             conflict_q;
    logic             conflict_d;
    logic             we0;
    logic             we1;

    function automatic logic is_zero(input logic [ADDR_W-1:0] idx);
        return ZERO_ON && (idx == ZERO_IDX);
    endfunction

    // Writes aimed at the zero register are dropped before they reach the
    // array, the scoreboard or the conflict detector.
    assign we0        = RegWr0 && !is_zero(RW0);
    assign we1        = RegWr1 && !is_zero(RW1);
    assign conflict_d = we0 && we1 && (RW0 == RW1);

    // NOTE: blocking assignments in always_comb run in order, so a later
    // assignment to the same element overrides an earlier one; that ordering
    // is what gives port 1 priority and lets SetBusy beat a write's clear.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (we0) begin
            regs_d[RW0] = BusW0;
            busy_d[RW0] = 1'b0;
        end
        if (we1) begin
            regs_d[RW1] = BusW1;
            busy_d[RW1] = 1'b0;
        end
        if (SetBusy && !is_zero(BusyRW)) begin
            busy_d[BusyRW] = 1'b1;
        end
    end

    // NOTE: the storage is flops, not a RAM macro, so the whole array is
    // cleared by the asynchronous reset; a RAM-style array would not be.
    always_ff @(negedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            busy_q     <= '0;
            conflict_q <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            busy_q     <= busy_d;
            conflict_q <= conflict_d;
        end
    end

    function automatic logic wr_hit(input logic [ADDR_W-1:0] idx);
        return (RegWr0 && (RW0 == idx)) || (RegWr1 && (RW1 == idx));
    endfunction

    function automatic logic [WIDTH-1:0] read_port(input logic [ADDR_W-1:0] idx);
        if (is_zero(idx)) begin
            return '0;
        end
        if (BYP_ON && RegWr1 && (RW1 == idx)) begin
            return BusW1;
        end
        if (BYP_ON && RegWr0 && (RW0 == idx)) begin
            return BusW0;
        end
        return regs_q[idx];
    endfunction

    function automatic logic read_busy(input logic [ADDR_W-1:0] idx);
        return busy_q[idx] && !(BYP_ON && wr_hit(idx));
    endfunction

    // Reset forces every read output low, which also masks the bypass path.
    always_comb begin
        BusA  = '0;
        BusB  = '0;
        BusyA = 1'b0;
        BusyB = 1'b0;
        if (!Reset) begin
            BusA  = read_port(RA);
            BusB  = read_port(RB);
            BusyA = read_busy(RA);
            BusyB = read_busy(RB);
        end
    end

    assign WrConflict = conflict_q;

endmodule

// File: doc/regfile_2w2r_sb.md
Name: regfile_2w2r_sb

Overview:
- Parametrised successor to the single-write, two-read mini register file used by the single-cycle datapath.
- Adds the following:
  - configurable data width and depth;
  - a second write port with fixed priority;
  - optional write-to-read bypass;
  - configurable hardwired-zero register;
  - per-register busy scoreboard for the multi-cycle/pipelined datapath.
- Sits between decode (RA/RB/RW) and the ALU/memory writeback buses.

Parameters:
- WIDTH, 64, data width of every register and bus.
- ADDR_W, 5, register index width; depth = 2**ADDR_W.
- HAS_ZERO, 1, 1 = register ZERO_REG is hardwired to 0.
- ZERO_REG, 31, index of the zero register (XZR); ignored when HAS_ZERO=0.
- BYPASS, 1, 1 = same-cycle write data is forwarded to the read ports.

Ports:
- Clk, input, 1, clock. All state updates on the falling edge.
- Reset, input, 1, asynchronous, active-high.
- RA, input, ADDR_W, read port A index.
- RB, input, ADDR_W, read port B index.
- BusA, output, WIDTH, read data A (combinational).
- BusB, output, WIDTH, read data B (combinational).
- RW0, input, ADDR_W, write port 0 index (ALU writeback).
- BusW0, input, WIDTH, write port 0 data.
- RegWr0, input, 1, write port 0 enable.
- RW1, input, ADDR_W, write port 1 index (memory writeback).
- BusW1, input, WIDTH, write port 1 data.
- RegWr1, input, 1, write port 1 enable.
- SetBusy, input, 1, mark register BusyRW as having an outstanding producer.
- BusyRW, input, ADDR_W, index to mark busy.
- BusyA, output, 1, register RA has an outstanding producer.
- BusyB, output, 1, register RB has an outstanding producer.
- WrConflict, output, 1, registered flag: both write ports targeted the same register at the last falling edge.

Behaviour:
- Reset (asynchronous, active-high):
  - All registers go to 0, all busy bits go to 0, WrConflict goes to 0.
  - BusA, BusB, BusyA and BusyB read 0 while Reset is high. Bypass is suppressed during reset.
  - Reset asserted mid-operation aborts any pending write. Its deassertion does not create a write edge.
- Write, on the falling edge of Clk:
  - reg[RW0] <= BusW0 if RegWr0.
  - reg[RW1] <= BusW1 if RegWr1.
  - If both enables are high and RW0 == RW1, port 1 wins (younger memory result), and WrConflict <= 1.
  - Otherwise WrConflict <= 0. WrConflict holds for exactly one clock period.
  - With HAS_ZERO=1, writes to ZERO_REG are discarded and do not set WrConflict.
- Read (combinational, zero latency):
  - Index == ZERO_REG with HAS_ZERO=1: result is 0 regardless of bypass.
  - Else if BYPASS=1 and RegWr1 and RW1 == index: result is BusW1.
  - Else if BYPASS=1 and RegWr0 and RW0 == index: result is BusW0.
  - Else: result is reg[index].
  - With BYPASS=0, written data appears on a read port only after the falling edge that commits it.
- Scoreboard, on the falling edge of Clk:
  - An enabled write clears busy[RWn].
  - SetBusy sets busy[BusyRW].
  - SetBusy and a write to the same index at the same edge: set wins (a new producer was issued).
  - ZERO_REG (HAS_ZERO=1) is never marked busy.
  - BusyA = busy[RA], forced to 0 when BYPASS=1 and an enabled write to RA is present this cycle. BusyB is defined the same way with RB.
- Corner cases:
  - RA == RB: both buses return identical data.
  - Indices wrap naturally within ADDR_W bits; there are no out-of-range indices.
  - A non-power-of-two depth is not supported.

Test Plan:
1. Reset → all registers 0:
   - Assert Reset; write 0xFF to reg 5 with RegWr0=1 while Reset is high, then deassert.
   - Required: RA=5 gives BusA=0. RA=31 gives BusA=0 at every step.
2. Zero register and port 0 persistence:
   - Write 64'h12345678 to reg 31 via port 0, then to reg 1.
   - Required: after the falling edge, RA=31 gives 0 and RA=1 gives 0x12345678.
   - Required: with RegWr0=0 and BusW0=0xDEAD, reg 1 still reads 0x12345678.
3. Dual-write conflict:
   - RW0=RW1=4, BusW0=0xAAAA, BusW1=0xBBBB, both enables high, one falling edge.
   - Required: RA=4 gives 0xBBBB; WrConflict=1 for one period, then 0.
   - Required: the same stimulus with RW0=RW1=31 gives WrConflict=0.
4. Bypass:
   - BYPASS=1: RA=7, RegWr0=1, RW0=7, BusW0=0x77 before the edge.
   - Required: BusA=0x77 immediately.
   - Required: with BYPASS=0, BusA shows the old value (0) until after the falling edge, then 0x77.
5. Scoreboard:
   - SetBusy with BusyRW=9 at edge N. Required: BusyA=1 for RA=9.
   - RegWr1=1, RW1=9 during cycle N+1. Required: BusyA=0 in the same cycle (bypass); busy bit cleared after the edge.
   - SetBusy on 9 plus a write to 9 at the same edge. Required: BusyA=1 afterwards.
6. Parametrised instance:
   - WIDTH=32, ADDR_W=4, HAS_ZERO=0: write 0xFFFFFFFF to reg 15.
   - Required: reads back 0xFFFFFFFF; reg 15 is writable.
